// File: rtl/data_mem_responder.sv
// Single-port data memory responder: one request in flight, IDLE -> ACCESS -> RESP.
// Define MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of force-aligning them.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_store,
    input  logic [3:0]  req_wstrb,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_func3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic        cap_en;
    logic        access_en;
    logic        mem_we;

    logic [31:0] addr_q;
    logic        store_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;
    logic [2:0]  func3_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [1:0]       off;
    logic [1:0]       eff_off;
    logic             is_half;
    logic             is_word;
    logic             func3_ok;
    logic             range_fault;
    logic             misalign;
    logic             fault;
    logic [IDX_W-1:0] word_idx;
    logic [3:0]       lane_en;
    logic [31:0]      wr_data;
    logic [31:0]      rd_word;
    logic [31:0]      rd_shift;
    logic [31:0]      ld_data;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        cap_en    = 1'b0;
        access_en = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cap_en  = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                access_en = 1'b1;
                state_d   = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- Request capture ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            store_q <= 1'b0;
            wstrb_q <= '0;
            wdata_q <= '0;
            func3_q <= '0;
        end else if (cap_en) begin
            addr_q  <= req_addr;
            store_q <= req_store;
            wstrb_q <= req_wstrb;
            wdata_q <= req_wdata;
            func3_q <= req_func3;
        end
    end

    // ---------------- Access decode ----------------
    // Stores take their access width from the strobe pattern; loads from func3.
    always_comb begin
        off      = addr_q[1:0];
        func3_ok = (func3_q == 3'b000) || (func3_q == 3'b001) || (func3_q == 3'b010) ||
                   (func3_q == 3'b100) || (func3_q == 3'b101);
        if (store_q) begin
            is_word = (wstrb_q == 4'b1111);
            is_half = (wstrb_q == 4'b0011);
        end else begin
            is_word = (func3_q[1:0] == 2'b10);
            is_half = (func3_q[1:0] == 2'b01);
        end
`ifdef MISALIGN_TRAP_EN
        misalign = (is_half && off[0]) || (is_word && (off != 2'b00));
        eff_off  = off;
`else
        misalign = 1'b0;
        if (is_word) begin
            eff_off = 2'b00;
        end else if (is_half) begin
            eff_off = {off[1], 1'b0};
        end else begin
            eff_off = off;
        end
`endif
        range_fault = ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
        fault       = range_fault || misalign || (!store_q && !func3_ok);
        word_idx    = addr_q[IDX_W+1:2];
    end

    // Shifting left in a 4-bit/32-bit container drops lanes past byte 3.
    always_comb begin
        lane_en = wstrb_q << eff_off;
        wr_data = wdata_q << {eff_off, 3'b000};
        mem_we  = access_en && store_q && !fault;
    end

    // ---------------- Storage (not reset) ----------------
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // ---------------- Load path ----------------
    always_comb begin
        rd_word  = mem[word_idx];
        rd_shift = rd_word >> {eff_off, 3'b000};
        case (func3_q)
            3'b000:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  ld_data = rd_shift;
            3'b100:  ld_data = {24'h000000, rd_shift[7:0]};
            3'b101:  ld_data = {16'h0000, rd_shift[15:0]};
            default: ld_data = '0;
        endcase
    end

    // ---------------- Response registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
        end else if (access_en) begin
            rsp_rdata <= (store_q || fault) ? '0 : ld_data;
            rsp_fault <= fault;
        end else if (rsp_valid && rsp_ready) begin
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus randomized
// traffic against a byte-addressed reference memory model.
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 256;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_store;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic [2:0]  req_func3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    logic [7:0] ref_mem [4*DEPTH];

    data_mem_responder #(.DEPTH_WORDS(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_store (req_store),
        .req_wstrb (req_wstrb),
        .req_wdata (req_wdata),
        .req_func3 (req_func3),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_fault (rsp_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: byte-addressed memory, width from strobe (stores) or func3 (loads).
    task automatic model(input logic [31:0] addr, input logic store, input logic [3:0] wstrb,
                         input logic [31:0] wdata, input logic [2:0] func3,
                         output logic [31:0] exp_rdata, output logic exp_fault);
        int unsigned sz;
        int unsigned base;
        logic [31:0] v;
        exp_fault = 1'b0;
        exp_rdata = '0;
        if (store) sz = (wstrb == 4'b1111) ? 4 : (wstrb == 4'b0011) ? 2 : 1;
        else       sz = (func3[1:0] == 2'b10) ? 4 : (func3[1:0] == 2'b01) ? 2 : 1;
        if (!store && (func3 == 3'd3 || func3 >= 3'd6)) exp_fault = 1'b1;
        if ((addr >> 2) >= DEPTH) exp_fault = 1'b1;
`ifdef MISALIGN_TRAP_EN
        if (addr % sz != 0) exp_fault = 1'b1;
        base = addr;
`else
        base = addr - (addr % sz);
`endif
        if (exp_fault) return;
        if (store) begin
            for (int unsigned k = 0; k < 4; k++)
                if (wstrb[k] && (base % 4 + k) < 4)
                    ref_mem[base + k] = 8'(wdata >> (8 * k));
        end else begin
            v = '0;
            for (int unsigned i = 0; i < sz; i++)
                v = v | (32'(ref_mem[base + i]) << (8 * i));
            if (!func3[2] && sz < 4 && v[8*sz-1])
                v = v | (32'hFFFF_FFFF << (8 * sz));
            exp_rdata = v;
        end
    endtask

    // Present a request in IDLE; after accept keep req_valid high with junk to prove it is ignored.
    task automatic drive_req(input logic [31:0] addr, input logic store, input logic [3:0] wstrb,
                             input logic [31:0] wdata, input logic [2:0] func3);
        @(negedge clk);
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_store = store;
        req_wstrb = wstrb;
        req_wdata = wdata;
        req_func3 = func3;
        @(posedge clk);
        #1;
        req_addr  = $urandom;
        req_store = 1'($urandom);
        req_wstrb = 4'($urandom);
        req_wdata = $urandom;
        req_func3 = 3'($urandom);
    endtask

    task automatic do_txn(input logic [31:0] addr, input logic store, input logic [3:0] wstrb,
                          input logic [31:0] wdata, input logic [2:0] func3, input int unsigned delay,
                          output logic [31:0] obs_rdata, output logic obs_fault);
        logic [31:0] er;
        logic        ef;
        model(addr, store, wstrb, wdata, func3, er, ef);
        drive_req(addr, store, wstrb, wdata, func3);
        chk("access_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("access_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("lat2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_rdata", rsp_rdata, er);
        chk("rsp_fault", 32'(rsp_fault), 32'(ef));
        obs_rdata = rsp_rdata;
        obs_fault = rsp_fault;
        for (int unsigned c = 0; c < delay; c++) begin
            @(posedge clk);
            #1;
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, er);
            chk("hold_fault", 32'(rsp_fault), 32'(ef));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_hs_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] r;
        logic        f;
        logic [31:0] a;
        logic [3:0]  s;
        int unsigned pick;

        rst_n = 1'b0;
        req_valid = 1'b0;
        req_addr = '0;
        req_store = 1'b0;
        req_wstrb = '0;
        req_wdata = '0;
        req_func3 = '0;
        rsp_ready = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_fault", 32'(rsp_fault), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Give every word a known value.
        for (int unsigned w = 0; w < DEPTH; w++)
            do_txn(32'(4 * w), 1'b1, 4'hF, $urandom, 3'd0, 0, r, f);

        // Word store/load, then byte store with sign/zero extension.
        do_txn(32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 3'd0, 0, r, f);
        do_txn(32'h10, 1'b0, 4'h0, 32'h0, 3'b010, 1, r, f);
        chk("dir_word_load", r, 32'hDEADBEEF);
        do_txn(32'h13, 1'b1, 4'b0001, 32'h80, 3'd0, 0, r, f);
        do_txn(32'h13, 1'b0, 4'h0, 32'h0, 3'b000, 0, r, f);
        chk("dir_lb_sign", r, 32'hFFFFFF80);
        do_txn(32'h13, 1'b0, 4'h0, 32'h0, 3'b100, 0, r, f);
        chk("dir_lbu_zero", r, 32'h00000080);
        do_txn(32'h10, 1'b0, 4'h0, 32'h0, 3'b010, 0, r, f);
        chk("dir_word_merged", r, 32'h80ADBEEF);
        do_txn(32'h12, 1'b0, 4'h0, 32'h0, 3'b010, 0, r, f);
`ifdef MISALIGN_TRAP_EN
        chk("dir_misalign_fault", 32'(f), 32'd1);
        chk("dir_misalign_rdata", r, 32'd0);
`else
        chk("dir_align_rdata", r, 32'h80ADBEEF);
        chk("dir_align_fault", 32'(f), 32'd0);
`endif
        // Out-of-range store must fault and leave word 0 alone.
        do_txn(32'h0, 1'b1, 4'hF, 32'h0BADF00D, 3'd0, 0, r, f);
        do_txn(32'(4 * DEPTH), 1'b1, 4'hF, 32'h12345678, 3'd0, 0, r, f);
        chk("dir_oor_fault", 32'(f), 32'd1);
        do_txn(32'h0, 1'b0, 4'h0, 32'h0, 3'b010, 0, r, f);
        chk("dir_word0_kept", r, 32'h0BADF00D);
        do_txn(32'h4, 1'b0, 4'h0, 32'h0, 3'b011, 0, r, f);
        chk("dir_bad_func3", 32'(f), 32'd1);
        do_txn(32'h8, 1'b1, 4'h0, 32'hFFFFFFFF, 3'd0, 0, r, f);
        chk("dir_zero_strb_fault", 32'(f), 32'd0);
        // Long backpressure.
        do_txn(32'h10, 1'b0, 4'h0, 32'h0, 3'b101, 5, r, f);

        // Reset during ACCESS cancels the store.
        do_txn(32'h20, 1'b1, 4'hF, 32'hCAFE0020, 3'd0, 0, r, f);
        drive_req(32'h20, 1'b1, 4'hF, 32'h11111111, 3'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_acc_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_acc_req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_acc_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(32'h20, 1'b0, 4'h0, 32'h0, 3'b010, 0, r, f);
        chk("rst_acc_prior", r, 32'hCAFE0020);

        // Reset during RESP drops the response.
        drive_req(32'h20, 1'b0, 4'h0, 32'h0, 3'b010);
        @(posedge clk);
        #1;
        chk("resp_before_rst", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_resp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_resp_rdata", rsp_rdata, 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic.
        for (int unsigned n = 0; n < 400; n++) begin
            pick = $urandom_range(0, 15);
            if (pick == 0)      a = $urandom;
            else if (pick == 1) a = $urandom_range(4 * DEPTH, 4 * DEPTH + 255);
            else                a = $urandom_range(0, 4 * DEPTH - 1);
            case ($urandom_range(0, 4))
                0: s = 4'b0001;
                1: s = 4'b0011;
                2: s = 4'b1111;
                3: s = 4'b0000;
                default: s = 4'($urandom);
            endcase
            do_txn(a, 1'($urandom), s, $urandom, 3'($urandom), $urandom_range(0, 3), r, f);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit words of storage.
REQ-002 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid, input, 1: request present.
REQ-005 SHALL have port req_ready, output, 1: request accepted when req_valid && req_ready.
REQ-006 SHALL have port req_addr, input, 32: byte address.
REQ-007 SHALL have port req_store, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_wstrb, input, 4: byte mask aligned to lane 0 (0001 byte, 0011 half, 1111 word).
REQ-009 SHALL have port req_wdata, input, 32: store data, right-aligned.
REQ-010 SHALL have port req_func3, input, 3: load width/sign code.
REQ-011 SHALL have port rsp_valid, output, 1: response present.
REQ-012 SHALL have port rsp_ready, input, 1: response consumed when rsp_valid && rsp_ready.
REQ-013 SHALL have port rsp_rdata, output, 32: extended load data; 0 for stores and faults.
REQ-014 SHALL have port rsp_fault, output, 1: access rejected; no memory write.

Function
REQ-015 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; req_ready = 1 only in IDLE.
REQ-016 SHALL capture addr, store, wstrb, wdata, func3 on accept and move IDLE -> ACCESS.
REQ-017 SHALL perform the single memory read or write in ACCESS, then move to RESP unconditionally.
REQ-018 SHALL hold rsp_valid = 1 and rsp_rdata/rsp_fault stable in RESP until rsp_ready; handshake moves RESP -> IDLE.
REQ-019 Accept-to-rsp_valid latency SHALL be exactly 2 cycles; next request accepted no earlier than cycle after response handshake.
REQ-020 Stores SHALL shift wstrb and wdata left by addr[1:0] bytes; only enabled lanes written; wstrb = 0000 writes nothing, no fault.
REQ-021 Loads SHALL shift read word right by 8*addr[1:0], then extend: 000 sign byte, 001 sign half, 010 word, 100 zero byte, 101 zero half.
REQ-022 Load func3 of 011, 110, 111 SHALL set rsp_fault = 1, rsp_rdata = 0.
REQ-023 Word index addr[31:2] >= DEPTH_WORDS SHALL set rsp_fault = 1, suppress write, rsp_rdata = 0.
REQ-024 Store strobe shifted beyond lane 3 SHALL drop the overflow lanes (no wrap into next word) unless faulted per REQ-030.
REQ-025 req_valid while not in IDLE SHALL be ignored; inputs sampled only on accept.

Reset
REQ-026 rst_n low SHALL force FSM to IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_fault = 0 immediately.
REQ-027 Reset during ACCESS before the clock edge SHALL cancel the pending write; reset during RESP SHALL drop the response.
REQ-028 Storage array SHALL NOT be reset; contents undefined until written.

Configuration
REQ-029 Macro MISALIGN_TRAP_EN SHALL select misalignment handling.
REQ-030 With MISALIGN_TRAP_EN defined: half access with addr[0] = 1 or word access with addr[1:0] != 0 SHALL set rsp_fault = 1, no write, rsp_rdata = 0.
REQ-031 Without MISALIGN_TRAP_EN: half access SHALL force addr[0] = 0, word access SHALL force addr[1:0] = 0; never faults for alignment.

Verification
REQ-032 Store word 0xDEADBEEF @0x10 wstrb 1111, then load func3 010 @0x10 -> rsp_rdata 0xDEADBEEF, fault 0, rsp_valid 2 cycles after accept.
REQ-033 Store byte 0x80 @0x13 wstrb 0001, load 000 @0x13 -> 0xFFFFFF80; load 100 @0x13 -> 0x00000080; load 010 @0x10 -> 0x80ADBEEF.
REQ-034 Load 010 @0x12: with MISALIGN_TRAP_EN -> fault 1, rdata 0; without -> rdata 0x80ADBEEF, fault 0.
REQ-035 Store @ 4*DEPTH_WORDS (0x400 default) -> fault 1; reload of word 0 unchanged.
REQ-036 rsp_ready held 0 for 5 cycles -> rsp_valid, rdata stable, req_ready 0 throughout; release -> IDLE next cycle.
REQ-037 rst_n pulsed low in ACCESS of store 0x11111111 @0x20 -> no response, later load @0x20 returns prior value.
